// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard control: load-use and MDU scoreboard stalls, branch flush, launch of the single MDU.
// Hazard outputs are same-cycle combinational; FSM, watchdog and stall counter update on the clock edge.
module hazard_stall_ctrl #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_Valid_i,
  input  logic [REG_AW-1:0] ID_Rs1_i,
  input  logic [REG_AW-1:0] ID_Rs2_i,
  input  logic              ID_UseRs1_i,
  input  logic              ID_UseRs2_i,
  input  logic [REG_AW-1:0] ID_Rd_i,
  input  logic              ID_IsMulDiv_i,
  input  logic              EX_MemRead_i,
  input  logic [REG_AW-1:0] EX_Rd_i,
  input  logic              EX_BranchTaken_i,
  input  logic              MDU_Done_i,
  output logic              PCWrite_o,
  output logic              IF_ID_Write_o,
  output logic              IF_ID_Flush_o,
  output logic              ID_EX_Bubble_o,
  output logic              MDU_Start_o,
  output logic              MDU_Busy_o,
  output logic              MDU_Timeout_o,
  output logic [CNT_W-1:0]  Stall_Cnt_o
);

  localparam int WD_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t            state;
  logic [REG_AW-1:0] pend_rd;
  logic [WD_W-1:0]   wd_cnt;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt;

  logic busy, hit_ex, hit_pend, lu, md_raw, md_str, stall, launch;

  assign busy = (state == MD_WAIT);

  // Register 0 is hardwired zero, so a match on it is never a real dependency.
  assign hit_ex   = ID_Valid_i & (EX_Rd_i != '0) &
                    ((ID_UseRs1_i & (ID_Rs1_i == EX_Rd_i)) | (ID_UseRs2_i & (ID_Rs2_i == EX_Rd_i)));
  assign hit_pend = ID_Valid_i & (pend_rd != '0) &
                    ((ID_UseRs1_i & (ID_Rs1_i == pend_rd)) | (ID_UseRs2_i & (ID_Rs2_i == pend_rd)));

  assign lu     = EX_MemRead_i & hit_ex;
  assign md_raw = busy & hit_pend;
  assign md_str = busy & ID_Valid_i & ID_IsMulDiv_i;
  assign stall  = (lu | md_raw | md_str) & ~EX_BranchTaken_i;
  assign launch = (state == RUN) & ID_Valid_i & ID_IsMulDiv_i & ~stall & ~EX_BranchTaken_i;

  assign PCWrite_o      = ~rst_i & ~stall;
  assign IF_ID_Write_o  = ~rst_i & ~stall;
  assign IF_ID_Flush_o  = ~rst_i & EX_BranchTaken_i;
  assign ID_EX_Bubble_o = rst_i | stall | EX_BranchTaken_i;
  assign MDU_Start_o    = ~rst_i & launch;
  assign MDU_Busy_o     = busy;
  assign MDU_Timeout_o  = timeout_q;
  assign Stall_Cnt_o    = stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      pend_rd   <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        RUN: begin
          // Done while idle is stray and ignored.
          if (launch) begin
            pend_rd <= ID_Rd_i;
            wd_cnt  <= '0;
            state   <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          // A taken branch never cancels the op: it is older than the branch.
          if (MDU_Done_i) begin
            state   <= RUN;
            pend_rd <= '0;
            wd_cnt  <= '0;
          end else if (wd_cnt == WD_LAST) begin
            timeout_q <= 1'b1;
            state     <= RUN;
            pend_rd   <= '0;
            wd_cnt    <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
